// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider: state encodings,
// default operand widths and the iteration-counter width helper.
package seq_div_pkg;

   // Default widths: dividend/quotient and divisor/remainder.
   localparam int DEF_DW = 10;
   localparam int DEF_VW = 6;

   // Controller states. The encodings are fixed so that waveforms and
   // debug probes read the same across the arithmetic lab blocks.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // The step counter is loaded with DW and has to represent that value.
   function automatic int cnt_width(input int dw);
      return $clog2(dw + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// bring in the next dividend bit, and trial-subtract the divisor magnitude.
// Purely combinational; the controller registers the result each CALC cycle.
module div_step #(
   parameter int VW = 6
) (
   input  logic [VW:0]   prem,      // partial remainder, always < absv
   input  logic          din,       // next dividend bit, MSB first
   input  logic [VW-1:0] absv,      // divisor magnitude, 1 .. 2^(VW-1)
   output logic [VW:0]   prem_nxt,  // partial remainder after this step
   output logic          qbit       // quotient bit produced by this step
);

   logic [VW+1:0] shifted;

   // Trial subtract; keep the difference when it does not go negative,
   // otherwise restore the shifted remainder unchanged.
   always_comb begin
      shifted  = {prem, din};
      qbit     = (shifted >= {2'b00, absv});
      prem_nxt = shifted[VW:0];
      if (qbit) begin
         prem_nxt = shifted[VW:0] - {1'b0, absv};
      end
   end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle signed restoring divider with a start/busy/done handshake.
// Quotient truncates toward zero; the remainder takes the sign of the
// dividend. Division is done on magnitudes and the signs are restored in
// a single fix-up cycle. Results are held until the next accepted start.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int VW = DEF_VW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz,
   output logic          ovf
);

   localparam int CW = cnt_width(DW);

   // Magnitude of the most negative quotient; only reachable as a positive
   // result by -2^(DW-1) / -1, which cannot be represented.
   localparam logic [DW-1:0] QMAG_OVF = {1'b1, {(DW-1){1'b0}}};

   state_t        state;
   logic          sign_q;
   logic          sign_r;
   logic [DW-1:0] dreg;     // dividend magnitude, shifted out MSB first
   logic [DW-1:0] qmag;     // quotient magnitude, shifted in LSB first
   logic [VW-1:0] absv;     // divisor magnitude
   logic [VW:0]   prem;     // partial remainder
   logic [CW-1:0] cnt;      // restoring steps still to run

   logic [DW-1:0] abs_dvd;
   logic [VW-1:0] abs_dvs;
   logic [VW:0]   prem_nxt;
   logic          qbit;
   logic [DW-1:0] q_fix;
   logic [VW-1:0] r_fix;
   logic          ovf_fix;

   // Operand magnitudes; the most negative values map onto 2^(W-1), which
   // still fits the unsigned width.
   always_comb begin
      abs_dvd = dividend;
      abs_dvs = divisor;
      if (dividend[DW-1]) abs_dvd = -dividend;
      if (divisor[VW-1])  abs_dvs = -divisor;
   end

   div_step #(
      .VW (VW)
   ) u_step (
      .prem     (prem),
      .din      (dreg[DW-1]),
      .absv     (absv),
      .prem_nxt (prem_nxt),
      .qbit     (qbit)
   );

   // Sign restoration for the fix-up cycle. A negated 2^(DW-1) magnitude
   // wraps onto itself, which is the intended -2^(DW-1) result.
   always_comb begin
      q_fix   = qmag;
      r_fix   = prem[VW-1:0];
      if (sign_q) q_fix = -qmag;
      if (sign_r) r_fix = -prem[VW-1:0];
      ovf_fix = !sign_q && (qmag == QMAG_OVF);
   end

   // Controller and datapath registers; every output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         dbz       <= 1'b0;
         ovf       <= 1'b0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dreg      <= '0;
         qmag      <= '0;
         absv      <= '0;
         prem      <= '0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (start) begin
                  if (divisor == '0) begin
                     // Divide by zero: no iterations, report immediately.
                     state     <= DONE;
                     done      <= 1'b1;
                     quotient  <= '0;
                     remainder <= '0;
                     dbz       <= 1'b1;
                     ovf       <= 1'b0;
                  end else begin
                     state  <= CALC;
                     busy   <= 1'b1;
                     sign_q <= dividend[DW-1] ^ divisor[VW-1];
                     sign_r <= dividend[DW-1];
                     dreg   <= abs_dvd;
                     absv   <= abs_dvs;
                     prem   <= '0;
                     qmag   <= '0;
                     cnt    <= CW'(DW);
                  end
               end
            end
            CALC: begin
               prem <= prem_nxt;
               qmag <= {qmag[DW-2:0], qbit};
               dreg <= {dreg[DW-2:0], 1'b0};
               cnt  <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               state     <= DONE;
               busy      <= 1'b0;
               done      <= 1'b1;
               quotient  <= q_fix;
               remainder <= r_fix;
               dbz       <= 1'b0;
               ovf       <= ovf_fix;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed sign/boundary cases, divide by
// zero, handshake corner cases, mid-operation reset and random operands
// against an integer-arithmetic reference model.
module tb_seq_div;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [9:0] dividend;
   logic [5:0] divisor;
   logic       busy;
   logic       done;
   logic [9:0] quotient;
   logic [5:0] remainder;
   logic       dbz;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   seq_div #(.DW(10), .VW(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   // Reference: SV integer division truncates toward zero and % takes the
   // dividend's sign; the quotient is then wrapped to 10 bits.
   task automatic model(input int a, input int b, output logic [9:0] q,
                        output logic [5:0] r, output logic z, output logic o);
      int qi, ri;
      if (b == 0) begin
         q = '0; r = '0; z = 1'b1; o = 1'b0;
      end else begin
         qi = a / b;
         ri = a % b;
         q  = qi[9:0];
         r  = ri[5:0];
         z  = 1'b0;
         o  = (qi > 511);
      end
   endtask

   // Present operands with start at the current negedge.
   task automatic launch(input int a, input int b);
      dividend = 10'(a);
      divisor  = 6'(b);
      start    = 1'b1;
   endtask

   // Drop start after the accepting edge and count cycles until done.
   task automatic wait_done(output int cyc, output int bcnt);
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      bcnt  = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_div(input int a, input int b, output int cyc, output int bcnt);
      @(negedge clk);
      launch(a, b);
      wait_done(cyc, bcnt);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, quotient, remainder, dbz, ovf} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0", {busy, done, quotient, remainder, dbz, ovf});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int cyc, bcnt;
      do_div(100, 7, cyc, bcnt);
      checks++;
      if (cyc !== 12) begin errors++; $display("FAIL basic_latency got %0d exp 12", cyc); end
      checks++;
      if (bcnt !== 11) begin errors++; $display("FAIL basic_busy got %0d exp 11", bcnt); end
      checks++;
      if ({quotient, remainder, dbz, ovf} !== {10'd14, 6'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_result got q=%0d r=%0d dbz=%b ovf=%b exp q=14 r=2 dbz=0 ovf=0",
                  $signed(quotient), $signed(remainder), dbz, ovf);
      end
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++; $display("FAIL basic_pulse got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   // Sign combinations and boundary cases with constants worked out by hand.
   task automatic test_signs;
      int ta[9] = '{100, -100, 100, -100, -30, -512, -512, 511, 5};
      int tb[9] = '{7, 7, -7, -7, 6, -1, 1, -32, 9};
      int tq[9] = '{14, -14, -14, 14, -5, -512, -512, -15, 0};
      int tr[9] = '{2, -2, 2, -2, 0, 0, 0, 31, 5};
      logic to[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
      int cyc, bcnt;
      logic [9:0] eq;
      logic [5:0] er;
      for (int i = 0; i < 9; i++) begin
         do_div(ta[i], tb[i], cyc, bcnt);
         eq = 10'(tq[i]);
         er = 6'(tr[i]);
         checks++;
         if (cyc !== 12) begin
            errors++; $display("FAIL sign_latency %0d/%0d got %0d exp 12", ta[i], tb[i], cyc);
         end
         checks++;
         if ({quotient, remainder, dbz, ovf} !== {eq, er, 1'b0, to[i]}) begin
            errors++;
            $display("FAIL sign_result %0d/%0d got q=%0d r=%0d dbz=%b ovf=%b exp q=%0d r=%0d dbz=0 ovf=%b",
                     ta[i], tb[i], $signed(quotient), $signed(remainder), dbz, ovf, tq[i], tr[i], to[i]);
         end
      end
   endtask

   task automatic test_dbz;
      int cyc, bcnt;
      do_div(37, 0, cyc, bcnt);
      checks++;
      if (cyc !== 1 || bcnt !== 0) begin
         errors++; $display("FAIL dbz_latency got cyc=%0d busy=%0d exp 1 0", cyc, bcnt);
      end
      checks++;
      if ({quotient, remainder, dbz, ovf} !== {10'd0, 6'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL dbz_result got q=%0d r=%0d dbz=%b ovf=%b exp 0 0 1 0",
                  $signed(quotient), $signed(remainder), dbz, ovf);
      end
      do_div(20, 3, cyc, bcnt);
      checks++;
      if ({quotient, remainder, dbz, ovf} !== {10'd6, 6'd2, 1'b0, 1'b0} || cyc !== 12) begin
         errors++;
         $display("FAIL dbz_clear got q=%0d r=%0d dbz=%b cyc=%0d exp 6 2 0 12",
                  $signed(quotient), $signed(remainder), dbz, cyc);
      end
   endtask

   task automatic test_start_held;
      int cyc = 0;
      int pulses = 0;
      @(negedge clk);
      launch(100, 7);
      while (pulses == 0 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done === 1'b1) pulses++;
         else begin
            dividend = 10'($urandom);
            divisor  = 6'($urandom_range(1, 31));
         end
      end
      start = 1'b0;
      checks++;
      if (cyc !== 12 || {quotient, remainder} !== {10'd14, 6'd2}) begin
         errors++;
         $display("FAIL held_result got cyc=%0d q=%0d r=%0d exp 12 14 2",
                  cyc, $signed(quotient), $signed(remainder));
      end
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 1 || busy !== 1'b0) begin
         errors++; $display("FAIL held_pulses got %0d busy=%b exp 1 0", pulses, busy);
      end
   endtask

   task automatic test_back_to_back;
      int cyc, bcnt;
      do_div(100, 7, cyc, bcnt);
      launch(-100, 7);          // still in the DONE cycle
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || quotient !== 10'd14) begin
         errors++;
         $display("FAIL b2b_accept got busy=%b q=%0d exp 1 14", busy, $signed(quotient));
      end
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 12 || {quotient, remainder} !== {-10'sd14, -6'sd2}) begin
         errors++;
         $display("FAIL b2b_result got cyc=%0d q=%0d r=%0d exp 12 -14 -2",
                  cyc, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_reset_mid;
      int cyc, bcnt;
      int pulses = 0;
      @(negedge clk);
      launch(100, 7);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, quotient, remainder, dbz, ovf} !== 20'd0) begin
         errors++;
         $display("FAIL midreset_outputs got %b exp 0", {busy, done, quotient, remainder, dbz, ovf});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset_nodone got pulses=%0d busy=%b exp 0 0", pulses, busy);
      end
      do_div(20, 3, cyc, bcnt);
      checks++;
      if (cyc !== 12 || {quotient, remainder, dbz, ovf} !== {10'd6, 6'd2, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midreset_after got cyc=%0d q=%0d r=%0d exp 12 6 2",
                  cyc, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_random;
      int a, b, cyc, bcnt;
      logic [9:0] eq;
      logic [5:0] er;
      logic ez, eo;
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(0, 1023)) - 512;
         b = int'($urandom_range(0, 63)) - 32;
         if (i == 0) begin a = -512; b = -32; end
         if (i == 1) begin a = 511;  b = 0;   end
         model(a, b, eq, er, ez, eo);
         do_div(a, b, cyc, bcnt);
         checks++;
         if (cyc !== (ez ? 1 : 12) ||
             {quotient, remainder, dbz, ovf} !== {eq, er, ez, eo}) begin
            errors++;
            $display("FAIL random %0d/%0d got q=%0d r=%0d dbz=%b ovf=%b cyc=%0d exp q=%0d r=%0d dbz=%b ovf=%b",
                     a, b, $signed(quotient), $signed(remainder), dbz, ovf, cyc,
                     $signed(eq), $signed(er), ez, eo);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_signs;
      test_dbz;
      test_start_held;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
